bus_dev_port: RTL and testbench
===============================

Name: bus_dev_port

Overview:
- Device-side endpoint that sits directly on one driver slot of the bus generator/arbiter (bs_gnrtr_n_rbtr).
- TX path: host words are buffered in a FIFO and presented to the bus as pndng/D_pop; the arbiter consumes them with pop.
- RX path: words the bus delivers via push/D_push are address-filtered against this device's ID or broadcast, then buffered for the host.
- One instance per driver; drvrs instances surround the arbiter.

Parameters:
- pckg_sz, 16, packet width in bits; the top 8 bits are the destination ID.
- profundidad, 8, depth of each FIFO in words; must be a power of 2, ≥2.
- dev_id, 0, this device's 8-bit ID on the bus.
- broadcast, 255, destination ID accepted by every device.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_wr  in  1  host write strobe into the TX FIFO.
- tx_data  in  pckg_sz  host write word.
- tx_full  out  1  TX FIFO full.
- tx_count  out  $clog2(profundidad)+1  TX occupancy.
- pndng  out  1  TX FIFO non-empty, to the arbiter.
- D_pop  out  pckg_sz  TX head word, to the arbiter (show-ahead).
- pop  in  1  arbiter consumes the TX head.
- push  in  1  arbiter delivers a word.
- D_push  in  pckg_sz  delivered word.
- rx_rd  in  1  host read strobe.
- rx_data  out  pckg_sz  RX head word (show-ahead).
- rx_valid  out  1  RX FIFO non-empty.
- rx_count  out  $clog2(profundidad)+1  RX occupancy.
- tx_ovf_cnt  out  8  TX writes dropped while full; saturating.
- rx_drop_cnt  out  8  accepted-address RX words dropped while full; saturating.
- pop_err  out  1  sticky; set by pop while TX is empty.

Behaviour:
- Reset (reset=0, async):
  - pointers, counts and counters go to 0; pop_err=0.
  - pndng=0, rx_valid=0, tx_full=0.
  - D_pop and rx_data are don't-care while the FIFO is empty; RTL drives them to 0.
  - Memory contents are not cleared.
- Reset asserted mid-operation discards all buffered words immediately; nothing is popped afterwards.
- Deassertion is taken synchronously by the flops: the first write is accepted on the first rising edge with reset=1.
- Both FIFOs are show-ahead. A word written at edge N appears at D_pop/rx_data with pndng/rx_valid=1 after edge N, i.e. one-cycle latency.
- pop and rx_rd advance the head at the edge; the next word is visible in the same following cycle.
- TX write rules:
  - tx_wr with tx_full=0: word stored, count+1.
  - tx_wr with tx_full=1 and pop=0: word dropped, tx_ovf_cnt+1 (saturate at 255).
  - tx_wr and pop in the same cycle while full: write accepted, count unchanged (the slot frees in that cycle).
  - tx_wr and pop in the same cycle while empty: pop ignored, pop_err set, write stored, count becomes 1.
- pop while empty and no write: ignored, pop_err=1 (sticky until reset).
- RX filter: a push is accepted only if D_push[pckg_sz-1 -: 8] equals dev_id or broadcast. Non-matching words are silently ignored, with no counter.
- RX write rules:
  - accepted push while RX is not full: stored.
  - accepted push while full and rx_rd=0: dropped, rx_drop_cnt+1 (saturate at 255).
  - accepted push and rx_rd while full: stored, count unchanged.
- rx_rd while empty: ignored, no flag.
- Pointers wrap modulo profundidad. Counts are the true occupancy, range 0..profundidad.
- tx_full = (tx_count == profundidad).
- Words are passed unmodified; the ID field is not stripped.

Decomposition:
- Shared package bus_pkg holds:
  - localparams ID_W=8 and BCAST_ID=255.
  - function get_dest(pkt) returning bits [pckg_sz-1 -: ID_W].
  - typedef for the occupancy width.
- One sub-module, bus_fifo (show-ahead synchronous FIFO with overflow/underflow strobes), instantiated twice.
- bus_dev_port contains only the filter, the counters and the pop_err logic.

Test Plan:
- Reset, then tx_wr three words 16'h05A1, 16'h05A2, 16'h05A3; no pop → pndng=1, D_pop=16'h05A1 one cycle after the first write; tx_count=3.
- Fill TX with 8 words, then 2 more writes with pop=0 → tx_full=1, tx_ovf_cnt=2. Next, tx_wr+pop together → count stays 8, new word emerges last in order.
- dev_id=3: push D_push 16'h0311, 16'h0422, 16'hFF33 → rx_count=2, rx_data sequence 16'h0311 then 16'hFF33; 16'h0422 is ignored and rx_drop_cnt=0.
- RX full (8 words), 300 more accepted pushes → rx_drop_cnt=255 (saturated), contents unchanged.
- pop on empty TX → pop_err=1 and stays 1. Assert reset low mid-cycle with 4 words buffered → pndng=0, all counters 0, pop_err=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: ID field geometry, destination extraction and
// saturating counter helper for the device port.
package bus_pkg;
  localparam int ID_W      = 8;
  localparam int BCAST_ID  = 255;
  localparam int PKT_MAX   = 64;
  localparam int DEPTH_DEF = 8;

  // Occupancy width for the default FIFO depth (0..DEPTH_DEF inclusive).
  typedef logic [$clog2(DEPTH_DEF):0] occ_t;

  // Destination ID lives in the top ID_W bits of a sz-bit packet.
  function automatic logic [ID_W-1:0] get_dest(input logic [PKT_MAX-1:0] pkt, input int sz);
    return ID_W'(pkt >> (sz - ID_W));
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/bus_fifo.sv
// Show-ahead synchronous FIFO; ovf/udf strobe on a rejected write / empty read.
module bus_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [W-1:0]             wdata,
  input  logic                     rd,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     udf
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_wr, do_rd;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  // A read while full frees the slot the same cycle, so the write still lands.
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);
  assign ovf   = wr & full & ~rd;
  assign udf   = rd & empty;
  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/bus_dev_port.sv
// Device endpoint on one arbiter driver slot: TX FIFO toward the bus,
// address-filtered RX FIFO toward the host, drop counters and pop_err.
module bus_dev_port
  import bus_pkg::*;
#(
  parameter int pckg_sz     = 16,
  parameter int profundidad = 8,
  parameter int dev_id      = 0,
  parameter int broadcast   = BCAST_ID
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tx_wr,
  input  logic [pckg_sz-1:0]             tx_data,
  output logic                           tx_full,
  output logic [$clog2(profundidad):0]   tx_count,
  output logic                           pndng,
  output logic [pckg_sz-1:0]             D_pop,
  input  logic                           pop,
  input  logic                           push,
  input  logic [pckg_sz-1:0]             D_push,
  input  logic                           rx_rd,
  output logic [pckg_sz-1:0]             rx_data,
  output logic                           rx_valid,
  output logic [$clog2(profundidad):0]   rx_count,
  output logic [7:0]                     tx_ovf_cnt,
  output logic [7:0]                     rx_drop_cnt,
  output logic                           pop_err
);
  localparam logic [ID_W-1:0] MY_ID = ID_W'(dev_id);
  localparam logic [ID_W-1:0] BC_ID = ID_W'(broadcast);

  logic            tx_empty, tx_ovf, tx_udf;
  logic            rx_empty, rx_ovf, rx_full_unused, rx_udf_unused;
  logic [ID_W-1:0] dest;
  logic            accept;

  assign dest   = get_dest(PKT_MAX'(D_push), pckg_sz);
  assign accept = push & ((dest == MY_ID) | (dest == BC_ID));

  bus_fifo #(.W(pckg_sz), .DEPTH(profundidad)) u_tx (
    .clk   (clk),
    .rst_n (reset),
    .wr    (tx_wr),
    .wdata (tx_data),
    .rd    (pop),
    .rdata (D_pop),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count),
    .ovf   (tx_ovf),
    .udf   (tx_udf)
  );

  bus_fifo #(.W(pckg_sz), .DEPTH(profundidad)) u_rx (
    .clk   (clk),
    .rst_n (reset),
    .wr    (accept),
    .wdata (D_push),
    .rd    (rx_rd),
    .rdata (rx_data),
    .empty (rx_empty),
    .full  (rx_full_unused),
    .count (rx_count),
    .ovf   (rx_ovf),
    .udf   (rx_udf_unused)
  );

  assign pndng    = ~tx_empty;
  assign rx_valid = ~rx_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf_cnt  <= '0;
      rx_drop_cnt <= '0;
      pop_err     <= 1'b0;
    end else begin
      if (tx_ovf) tx_ovf_cnt  <= sat_inc(tx_ovf_cnt);
      if (rx_ovf) rx_drop_cnt <= sat_inc(rx_drop_cnt);
      if (tx_udf) pop_err     <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bus_dev_port.sv
// Directed bench for bus_dev_port (dev_id=3, depth 8, 16-bit packets).
module tb_bus_dev_port;
  import bus_pkg::*;
  localparam int PW = 16;
  localparam int DEPTH = 8;

  logic          clk, reset;
  logic          tx_wr, pop, push, rx_rd;
  logic [PW-1:0] tx_data, D_pop, D_push, rx_data;
  logic          tx_full, pndng, rx_valid, pop_err;
  occ_t          tx_count, rx_count;
  logic [7:0]    tx_ovf_cnt, rx_drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q [$];

  bus_dev_port #(.pckg_sz(PW), .profundidad(DEPTH), .dev_id(3), .broadcast(255)) dut (
    .clk(clk), .reset(reset),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_count(tx_count),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count),
    .tx_ovf_cnt(tx_ovf_cnt), .rx_drop_cnt(rx_drop_cnt), .pop_err(pop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
    tx_data = '0; D_push = '0;
    #2;
    chk("rst_pndng",   32'(pndng), 32'd0);
    chk("rst_txcnt",   32'(tx_count), 32'd0);
    chk("rst_txfull",  32'(tx_full), 32'd0);
    chk("rst_rxvalid", 32'(rx_valid), 32'd0);
    chk("rst_poperr",  32'(pop_err), 32'd0);
    chk("rst_dpop",    32'(D_pop), 32'd0);
    tick;

    // Release reset together with the first write.
    reset = 1'b1; tx_wr = 1'b1; tx_data = 16'h05A1;
    tick;
    chk("first_pndng", 32'(pndng), 32'd1);
    chk("first_dpop",  32'(D_pop), 32'h05A1);
    tx_data = 16'h05A2; tick;
    tx_data = 16'h05A3; tick;
    tx_wr = 1'b0; tick;
    chk("tx_cnt3",  32'(tx_count), 32'd3);
    chk("head_05A1", 32'(D_pop), 32'h05A1);

    // Fill to 8 and overflow twice.
    tx_wr = 1'b1;
    for (int i = 4; i <= 8; i++) begin
      tx_data = 16'h05A0 + 16'(i); tick;
    end
    chk("tx_full", 32'(tx_full), 32'd1);
    chk("tx_cnt8", 32'(tx_count), 32'd8);
    tx_data = 16'h0BAD; tick; tick;
    chk("tx_ovf2", 32'(tx_ovf_cnt), 32'd2);
    chk("tx_cnt8b", 32'(tx_count), 32'd8);
    // Write + pop while full.
    pop = 1'b1; tx_data = 16'h05AF; tick;
    tx_wr = 1'b0; pop = 1'b0;
    chk("wrpop_cnt", 32'(tx_count), 32'd8);
    chk("wrpop_ovf", 32'(tx_ovf_cnt), 32'd2);
    for (int i = 2; i <= 8; i++) exp_q.push_back(16'h05A0 + 16'(i));
    exp_q.push_back(16'h05AF);
    while (exp_q.size() > 0) begin
      chk("tx_order", 32'(D_pop), 32'(exp_q.pop_front()));
      pop = 1'b1; tick;
    end
    pop = 1'b0;
    chk("tx_drained", 32'(pndng), 32'd0);
    chk("err_before", 32'(pop_err), 32'd0);

    // Pop on empty TX -> sticky pop_err.
    pop = 1'b1; tick; pop = 1'b0;
    chk("pop_err_set", 32'(pop_err), 32'd1);
    tick;
    chk("pop_err_stay", 32'(pop_err), 32'd1);
    chk("pop_empty_cnt", 32'(tx_count), 32'd0);

    // RX address filter.
    push = 1'b1;
    D_push = 16'h0311; tick;
    D_push = 16'h0422; tick;
    D_push = 16'hFF33; tick;
    push = 1'b0;
    chk("rx_cnt2",  32'(rx_count), 32'd2);
    chk("rx_head1", 32'(rx_data), 32'h0311);
    chk("rx_drop0", 32'(rx_drop_cnt), 32'd0);
    rx_rd = 1'b1; tick;
    chk("rx_head2", 32'(rx_data), 32'hFF33);
    tick; rx_rd = 1'b0;
    chk("rx_empty", 32'(rx_valid), 32'd0);
    rx_rd = 1'b1; tick; rx_rd = 1'b0;
    chk("rx_rd_empty", 32'(rx_count), 32'd0);

    // RX fill, then 300 dropped accepted pushes.
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      D_push = 16'h0300 + 16'(i); tick;
    end
    chk("rx_cnt8", 32'(rx_count), 32'd8);
    D_push = 16'hFF55;
    for (int i = 0; i < 300; i++) tick;
    chk("rx_drop_sat", 32'(rx_drop_cnt), 32'd255);
    chk("rx_cnt8b", 32'(rx_count), 32'd8);
    chk("rx_head_kept", 32'(rx_data), 32'h0300);
    // Push + read while full.
    D_push = 16'hFFEE; rx_rd = 1'b1; tick;
    push = 1'b0; rx_rd = 1'b0;
    chk("rx_pushrd_cnt", 32'(rx_count), 32'd8);
    chk("rx_pushrd_drop", 32'(rx_drop_cnt), 32'd255);
    for (int i = 1; i < 8; i++) exp_q.push_back(16'h0300 + 16'(i));
    exp_q.push_back(16'hFFEE);
    while (exp_q.size() > 0) begin
      chk("rx_order", 32'(rx_data), 32'(exp_q.pop_front()));
      rx_rd = 1'b1; tick;
    end
    rx_rd = 1'b0;
    chk("rx_drained", 32'(rx_valid), 32'd0);

    // Mid-cycle async reset with 4 TX words buffered.
    tx_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data = 16'h0C00 + 16'(i); tick;
    end
    tx_wr = 1'b0;
    chk("pre_rst_cnt", 32'(tx_count), 32'd4);
    #3 reset = 1'b0;
    #1;
    chk("arst_pndng",  32'(pndng), 32'd0);
    chk("arst_txcnt",  32'(tx_count), 32'd0);
    chk("arst_ovf",    32'(tx_ovf_cnt), 32'd0);
    chk("arst_drop",   32'(rx_drop_cnt), 32'd0);
    chk("arst_poperr", 32'(pop_err), 32'd0);
    tick;

    // Write + pop on empty: write stored, pop flagged.
    reset = 1'b1; tx_wr = 1'b1; pop = 1'b1; tx_data = 16'h07E7; tick;
    tx_wr = 1'b0; pop = 1'b0;
    chk("wrpop_empty_cnt", 32'(tx_count), 32'd1);
    chk("wrpop_empty_err", 32'(pop_err), 32'd1);
    chk("wrpop_empty_dat", 32'(D_pop), 32'h07E7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
